// File: rtl/s2mm_ring_scheduler_if.sv
// -----------------------------------------------------------------------------
// s2mm_ring_scheduler_if
// Purpose : Groups the DataMover S2MM command channel and status/halt signals
//           that connect the ring scheduler to the DataMover.
// Signals :
//   axis_cmd_tdata     [71:0] DataMover command word (scheduler -> DataMover)
//   axis_cmd_tvalid           command valid          (scheduler -> DataMover)
//   axis_cmd_tready           command accepted       (DataMover -> scheduler)
//   s2mm_wr_xfer_cmplt        one-cycle pulse per completed command
//   s2mm_err                  DataMover error
//   s2mm_halt                 halt request           (scheduler -> DataMover)
//   s2mm_halt_cmplt           halt acknowledged      (DataMover -> scheduler)
// Modports: master = scheduler side, slave = DataMover side.
// -----------------------------------------------------------------------------
interface s2mm_ring_scheduler_if;
    logic [71:0] axis_cmd_tdata;
    logic        axis_cmd_tvalid;
    logic        axis_cmd_tready;
    logic        s2mm_wr_xfer_cmplt;
    logic        s2mm_err;
    logic        s2mm_halt;
    logic        s2mm_halt_cmplt;

    modport master (
        output axis_cmd_tdata,
        output axis_cmd_tvalid,
        output s2mm_halt,
        input  axis_cmd_tready,
        input  s2mm_wr_xfer_cmplt,
        input  s2mm_err,
        input  s2mm_halt_cmplt
    );

    modport slave (
        input  axis_cmd_tdata,
        input  axis_cmd_tvalid,
        input  s2mm_halt,
        output axis_cmd_tready,
        output s2mm_wr_xfer_cmplt,
        output s2mm_err,
        output s2mm_halt_cmplt
    );
endinterface

// File: rtl/s2mm_ring_scheduler.sv
// -----------------------------------------------------------------------------
// s2mm_ring_scheduler
// Purpose : Issues fixed-size S2MM write commands walking a circular DDR buffer,
//           limits commands in flight, converts completions into a host-visible
//           write pointer and handles DataMover halt/error recovery.
// Ports   :
//   i_clk            AXI clock
//   i_rst            synchronous active-high reset
//   i_enable         acquisition run request (synchronised)
//   i_ddr_ready      DDR calibration complete (synchronised)
//   i_serdes_ready   ADC deserialiser locked (synchronised)
//   dm               DataMover command/status interface (master modport)
//   o_wr_ptr         completed byte offset within the ring
//   o_chunk_count    completed chunks since leaving IDLE
//   o_outstanding    commands accepted but not yet completed
//   o_busy           scheduler not in IDLE
//   o_error          sticky DataMover error flag
// -----------------------------------------------------------------------------
module s2mm_ring_scheduler #(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter logic [31:0] BUF_BYTES       = 32'h0800_0000,
    parameter int unsigned CHUNK_BYTES     = 4096,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic                  i_ddr_ready,
    input  logic                  i_serdes_ready,
    s2mm_ring_scheduler_if.master dm,
    output logic [31:0]           o_wr_ptr,
    output logic [31:0]           o_chunk_count,
    output logic [3:0]            o_outstanding,
    output logic                  o_busy,
    output logic                  o_error
);

    localparam logic [31:0] CHUNK_C    = 32'(CHUNK_BYTES);
    localparam logic [22:0] BTT_C      = 23'(CHUNK_BYTES);
    localparam logic [31:0] END_ADDR_C = BASE_ADDR + BUF_BYTES;
    localparam logic [3:0]  MAX_OUT_C  = 4'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_HALT  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    state_t      r_state;
    logic [71:0] r_tdata;
    logic        r_tvalid;
    logic        r_halt;
    logic [31:0] r_addr;
    logic [3:0]  r_tag;
    logic [31:0] r_wr_ptr;
    logic [31:0] r_chunk_count;
    logic [3:0]  r_outstanding;
    logic        r_busy;
    logic        r_error;

    logic        w_hs;
    logic        w_go;
    logic        w_active;
    logic        w_cmplt;
    logic [31:0] w_addr_inc;
    logic [31:0] w_addr_next;
    logic [31:0] w_wr_inc;
    logic [31:0] w_wr_next;

    // Command word: BTT, INCR, DSA=0, EOF, DRR=0, start address, tag, reserved.
    function automatic logic [71:0] build_cmd(input logic [31:0] addr, input logic [3:0] tag);
        build_cmd = {4'h0, tag, addr, 1'b0, 1'b1, 6'h00, 1'b1, BTT_C};
    endfunction

    assign w_hs     = r_tvalid & dm.axis_cmd_tready;
    assign w_go     = i_enable & i_ddr_ready & i_serdes_ready;
    // Completions only matter while commands can be in flight; ERROR discards them.
    assign w_active = (r_state == ST_RUN) || (r_state == ST_DRAIN) || (r_state == ST_HALT);
    // A completion with nothing in flight is spurious unless a command is accepted alongside it.
    assign w_cmplt  = dm.s2mm_wr_xfer_cmplt & w_active & ((r_outstanding != 4'd0) | w_hs);

    assign w_addr_inc  = r_addr + CHUNK_C;
    assign w_addr_next = (w_addr_inc == END_ADDR_C) ? BASE_ADDR : w_addr_inc;
    assign w_wr_inc    = r_wr_ptr + CHUNK_C;
    assign w_wr_next   = (w_wr_inc == BUF_BYTES) ? 32'd0 : w_wr_inc;

    // Scheduler FSM with ring bookkeeping; state-specific assignments below the
    // common bookkeeping override it (IDLE/ERROR hold their counters cleared).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_tdata       <= 72'd0;
            r_tvalid      <= 1'b0;
            r_halt        <= 1'b0;
            r_addr        <= BASE_ADDR;
            r_tag         <= 4'd0;
            r_wr_ptr      <= 32'd0;
            r_chunk_count <= 32'd0;
            r_outstanding <= 4'd0;
            r_busy        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            if (w_hs) begin
                r_addr <= w_addr_next;
                r_tag  <= r_tag + 4'd1;
            end
            if (w_cmplt) begin
                r_wr_ptr      <= w_wr_next;
                r_chunk_count <= r_chunk_count + 32'd1;
            end
            case ({w_hs, w_cmplt})
                2'b10:   r_outstanding <= r_outstanding + 4'd1;
                2'b01:   r_outstanding <= r_outstanding - 4'd1;
                default: r_outstanding <= r_outstanding;
            endcase

            case (r_state)
                ST_IDLE: begin
                    r_tvalid      <= 1'b0;
                    r_halt        <= 1'b0;
                    r_addr        <= BASE_ADDR;
                    r_tag         <= 4'd0;
                    r_wr_ptr      <= 32'd0;
                    r_chunk_count <= 32'd0;
                    r_outstanding <= 4'd0;
                    if (w_go) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (dm.s2mm_err) begin
                        // Error wins over a simultaneous run-request drop.
                        r_state  <= ST_HALT;
                        r_tvalid <= 1'b0;
                        r_halt   <= 1'b1;
                        r_error  <= 1'b1;
                    end else begin
                        // Drop valid for one cycle after each accept; pending counts toward the limit.
                        if (w_hs) begin
                            r_tvalid <= 1'b0;
                        end else if (w_go && !r_tvalid && (r_outstanding < MAX_OUT_C)) begin
                            r_tvalid <= 1'b1;
                            r_tdata  <= build_cmd(r_addr, r_tag);
                        end
                        if (!w_go) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (dm.s2mm_err) begin
                        r_state  <= ST_HALT;
                        r_tvalid <= 1'b0;
                        r_halt   <= 1'b1;
                        r_error  <= 1'b1;
                    end else begin
                        if (w_hs) begin
                            r_tvalid <= 1'b0;
                        end
                        if ((r_outstanding == 4'd0) && !r_tvalid) begin
                            r_state       <= ST_IDLE;
                            r_busy        <= 1'b0;
                            r_addr        <= BASE_ADDR;
                            r_tag         <= 4'd0;
                            r_wr_ptr      <= 32'd0;
                            r_chunk_count <= 32'd0;
                        end
                    end
                end
                ST_HALT: begin
                    r_tvalid <= 1'b0;
                    if (dm.s2mm_halt_cmplt) begin
                        r_state       <= ST_ERROR;
                        r_halt        <= 1'b0;
                        r_outstanding <= 4'd0;
                    end
                end
                ST_ERROR: begin
                    r_tvalid      <= 1'b0;
                    r_halt        <= 1'b0;
                    r_outstanding <= 4'd0;
                    if (!i_enable) begin
                        r_state       <= ST_IDLE;
                        r_busy        <= 1'b0;
                        r_error       <= 1'b0;
                        r_addr        <= BASE_ADDR;
                        r_tag         <= 4'd0;
                        r_wr_ptr      <= 32'd0;
                        r_chunk_count <= 32'd0;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_tvalid      <= 1'b0;
                    r_halt        <= 1'b0;
                    r_busy        <= 1'b0;
                    r_outstanding <= 4'd0;
                end
            endcase
        end
    end

    assign dm.axis_cmd_tdata  = r_tdata;
    assign dm.axis_cmd_tvalid = r_tvalid;
    assign dm.s2mm_halt       = r_halt;
    assign o_wr_ptr           = r_wr_ptr;
    assign o_chunk_count      = r_chunk_count;
    assign o_outstanding      = r_outstanding;
    assign o_busy             = r_busy;
    assign o_error            = r_error;

endmodule

// File: tb/tb_s2mm_ring_scheduler.sv
// -----------------------------------------------------------------------------
// tb_s2mm_ring_scheduler
// Directed, table-driven bench for s2mm_ring_scheduler with a 16 KiB ring of
// 4 KiB chunks and up to 4 commands in flight.
// -----------------------------------------------------------------------------
module tb_s2mm_ring_scheduler;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        ddr_ready;
    logic        serdes_ready;
    logic [31:0] wr_ptr;
    logic [31:0] chunk_count;
    logic [3:0]  outstanding;
    logic        busy;
    logic        error;

    int n_cmp;
    int n_err;

    s2mm_ring_scheduler_if dm_if();

    s2mm_ring_scheduler #(
        .BASE_ADDR       (32'h0000_0000),
        .BUF_BYTES       (32'h0000_4000),
        .CHUNK_BYTES     (4096),
        .MAX_OUTSTANDING (4)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_enable       (enable),
        .i_ddr_ready    (ddr_ready),
        .i_serdes_ready (serdes_ready),
        .dm             (dm_if),
        .o_wr_ptr       (wr_ptr),
        .o_chunk_count  (chunk_count),
        .o_outstanding  (outstanding),
        .o_busy         (busy),
        .o_error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        rdy;
        logic        cmplt;
        logic        err;
        logic        hc;
        logic        tv;
        logic [31:0] addr;
        logic [3:0]  tag;
        logic [3:0]  outst;
        logic [31:0] wr;
        logic [31:0] cnt;
        logic        busy;
        logic        halt;
        logic        error;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(input logic en, input logic rdy, input logic cmplt,
                                input logic err, input logic hc, input logic tv,
                                input logic [31:0] addr, input logic [3:0] tag,
                                input logic [3:0] outst, input logic [31:0] wr,
                                input logic [31:0] cnt, input logic b,
                                input logic h, input logic e);
        vec_t v;
        v.en = en; v.rdy = rdy; v.cmplt = cmplt; v.err = err; v.hc = hc;
        v.tv = tv; v.addr = addr; v.tag = tag; v.outst = outst; v.wr = wr;
        v.cnt = cnt; v.busy = b; v.halt = h; v.error = e;
        return v;
    endfunction

    // Expected command: BTT=0x1000, INCR=1, EOF=1 -> low word 0x4080_1000.
    function automatic logic [71:0] exp_cmd(input logic [31:0] addr, input logic [3:0] tag);
        return {4'h0, tag, addr, 32'h4080_1000};
    endfunction

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic chk_out(input string lbl, input logic tv, input logic [31:0] addr,
                           input logic [3:0] tag, input logic [3:0] outst,
                           input logic [31:0] wr, input logic [31:0] cnt,
                           input logic b, input logic h, input logic e);
        chk({lbl, " tvalid"}, 72'(dm_if.axis_cmd_tvalid), 72'(tv));
        if (tv) chk({lbl, " tdata"}, dm_if.axis_cmd_tdata, exp_cmd(addr, tag));
        chk({lbl, " outstanding"}, 72'(outstanding), 72'(outst));
        chk({lbl, " wr_ptr"}, 72'(wr_ptr), 72'(wr));
        chk({lbl, " chunk_count"}, 72'(chunk_count), 72'(cnt));
        chk({lbl, " busy"}, 72'(busy), 72'(b));
        chk({lbl, " halt"}, 72'(dm_if.s2mm_halt), 72'(h));
        chk({lbl, " error"}, 72'(error), 72'(e));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic rdy, input logic cmplt,
                         input logic err, input logic hc);
        enable                   = en;
        dm_if.axis_cmd_tready    = rdy;
        dm_if.s2mm_wr_xfer_cmplt = cmplt;
        dm_if.s2mm_err           = err;
        dm_if.s2mm_halt_cmplt    = hc;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;

        //            en rdy cm er hc | tv addr         tag  out  wr_ptr       cnt  b  h  e
        vecs[0]  = mk(1, 1, 0, 0, 0,   0, 32'h0,       4'd0, 4'd0, 32'h0,    32'd0, 1, 0, 0);
        vecs[1]  = mk(1, 1, 0, 0, 0,   1, 32'h0,       4'd0, 4'd0, 32'h0,    32'd0, 1, 0, 0);
        vecs[2]  = mk(1, 1, 0, 0, 0,   0, 32'h0,       4'd0, 4'd1, 32'h0,    32'd0, 1, 0, 0);
        vecs[3]  = mk(1, 1, 0, 0, 0,   1, 32'h1000,    4'd1, 4'd1, 32'h0,    32'd0, 1, 0, 0);
        vecs[4]  = mk(1, 1, 0, 0, 0,   0, 32'h0,       4'd0, 4'd2, 32'h0,    32'd0, 1, 0, 0);
        vecs[5]  = mk(1, 1, 0, 0, 0,   1, 32'h2000,    4'd2, 4'd2, 32'h0,    32'd0, 1, 0, 0);
        vecs[6]  = mk(1, 1, 0, 0, 0,   0, 32'h0,       4'd0, 4'd3, 32'h0,    32'd0, 1, 0, 0);
        vecs[7]  = mk(1, 1, 0, 0, 0,   1, 32'h3000,    4'd3, 4'd3, 32'h0,    32'd0, 1, 0, 0);
        vecs[8]  = mk(1, 1, 0, 0, 0,   0, 32'h0,       4'd0, 4'd4, 32'h0,    32'd0, 1, 0, 0);
        vecs[9]  = mk(1, 1, 0, 0, 0,   0, 32'h0,       4'd0, 4'd4, 32'h0,    32'd0, 1, 0, 0);
        vecs[10] = mk(1, 1, 1, 0, 0,   0, 32'h0,       4'd0, 4'd3, 32'h1000, 32'd1, 1, 0, 0);
        vecs[11] = mk(1, 1, 0, 0, 0,   1, 32'h0,       4'd4, 4'd3, 32'h1000, 32'd1, 1, 0, 0);
        vecs[12] = mk(1, 1, 0, 0, 0,   0, 32'h0,       4'd0, 4'd4, 32'h1000, 32'd1, 1, 0, 0);
        vecs[13] = mk(1, 1, 1, 0, 0,   0, 32'h0,       4'd0, 4'd3, 32'h2000, 32'd2, 1, 0, 0);
        vecs[14] = mk(1, 1, 1, 0, 0,   1, 32'h1000,    4'd5, 4'd2, 32'h3000, 32'd3, 1, 0, 0);
        // handshake and completion together: outstanding holds at 2, wr_ptr wraps to 0
        vecs[15] = mk(1, 1, 1, 0, 0,   0, 32'h0,       4'd0, 4'd2, 32'h0,    32'd4, 1, 0, 0);
        vecs[16] = mk(1, 1, 1, 0, 0,   1, 32'h2000,    4'd6, 4'd1, 32'h1000, 32'd5, 1, 0, 0);
        // error while a command is pending: halt, pending valid dropped
        vecs[17] = mk(1, 0, 0, 1, 0,   0, 32'h0,       4'd0, 4'd1, 32'h1000, 32'd5, 1, 1, 1);
        vecs[18] = mk(1, 0, 0, 0, 0,   0, 32'h0,       4'd0, 4'd1, 32'h1000, 32'd5, 1, 1, 1);
        vecs[19] = mk(1, 0, 0, 0, 1,   0, 32'h0,       4'd0, 4'd0, 32'h1000, 32'd5, 1, 0, 1);
        vecs[20] = mk(1, 0, 0, 0, 0,   0, 32'h0,       4'd0, 4'd0, 32'h1000, 32'd5, 1, 0, 1);
        vecs[21] = mk(0, 0, 0, 0, 0,   0, 32'h0,       4'd0, 4'd0, 32'h0,    32'd0, 0, 0, 0);

        // Reset state
        rst = 1'b1; ddr_ready = 1'b1; serdes_ready = 1'b1;
        drive(0, 0, 0, 0, 0);
        step();
        step();
        chk("reset tdata", dm_if.axis_cmd_tdata, 72'd0);
        chk_out("reset", 0, 32'h0, 4'd0, 4'd0, 32'h0, 32'd0, 0, 0, 0);
        rst = 1'b0;

        // Start gated by DDR calibration
        ddr_ready = 1'b0;
        drive(1, 1, 0, 0, 0);
        step();
        chk_out("no_ddr", 0, 32'h0, 4'd0, 4'd0, 32'h0, 32'd0, 0, 0, 0);
        ddr_ready = 1'b1;

        // Table: fill to limit, wrap, same-cycle accept/complete, error recovery
        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].en, vecs[i].rdy, vecs[i].cmplt, vecs[i].err, vecs[i].hc);
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].tv, vecs[i].addr, vecs[i].tag,
                    vecs[i].outst, vecs[i].wr, vecs[i].cnt, vecs[i].busy,
                    vecs[i].halt, vecs[i].error);
        end

        // Stalled command held stable, enable dropped, drained to IDLE
        drive(1, 0, 0, 0, 0);
        step();
        chk_out("stall_run", 0, 32'h0, 4'd0, 4'd0, 32'h0, 32'd0, 1, 0, 0);
        step();
        chk_out("stall_first", 1, 32'h0, 4'd0, 4'd0, 32'h0, 32'd0, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) enable = 1'b0;
            step();
            chk($sformatf("stall%0d tvalid", i), 72'(dm_if.axis_cmd_tvalid), 72'd1);
            chk($sformatf("stall%0d tdata", i), dm_if.axis_cmd_tdata, exp_cmd(32'h0, 4'd0));
        end
        drive(0, 1, 0, 0, 0);
        step();
        chk_out("drain_accept", 0, 32'h0, 4'd0, 4'd1, 32'h0, 32'd0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        step();
        chk_out("drain_wait", 0, 32'h0, 4'd0, 4'd1, 32'h0, 32'd0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        step();
        chk_out("drain_cmplt", 0, 32'h0, 4'd0, 4'd0, 32'h1000, 32'd1, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        step();
        chk_out("drain_idle", 0, 32'h0, 4'd0, 4'd0, 32'h0, 32'd0, 0, 0, 0);

        // Reset mid-operation with 3 in flight and one pending
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step();
        chk_out("pre_rst_o3", 0, 32'h0, 4'd0, 4'd3, 32'h0, 32'd0, 1, 0, 0);
        dm_if.axis_cmd_tready = 1'b0;
        step();
        chk_out("pre_rst_pend", 1, 32'h3000, 4'd3, 4'd3, 32'h0, 32'd0, 1, 0, 0);
        rst = 1'b1;
        step();
        chk("rst_mid tdata", dm_if.axis_cmd_tdata, 72'd0);
        chk_out("rst_mid", 0, 32'h0, 4'd0, 4'd0, 32'h0, 32'd0, 0, 0, 0);
        rst = 1'b0;
        drive(1, 1, 0, 0, 0);
        step();
        chk_out("restart_run", 0, 32'h0, 4'd0, 4'd0, 32'h0, 32'd0, 1, 0, 0);
        step();
        chk_out("restart_cmd", 1, 32'h0, 4'd0, 4'd0, 32'h0, 32'd0, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/s2mm_ring_scheduler.md
Name: s2mm_ring_scheduler

Overview:
- Sequences the S2MM DataMover that streams deserialised ADC samples into DDR3.
- Issues fixed-size write commands that walk a circular buffer in DDR.
- Limits the number of commands in flight and tracks completions into a host-visible write pointer.
- Handles halt/error recovery. Sits between GPIO control bits and the DataMover command channel, in the AXI clock domain.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of ring start in DDR
BUF_BYTES, 32'h0800_0000, ring size in bytes; integer multiple of CHUNK_BYTES
CHUNK_BYTES, 4096, bytes per command (BTT); multiple of 16, at most 2^23-1
MAX_OUTSTANDING, 4, maximum accepted-but-uncompleted commands (1..15)

Ports:
clk  in  1  AXI clock
rst  in  1  synchronous, active-high reset
enable  in  1  acquisition run request (already synchronised to clk)
ddr_ready  in  1  DDR calibration complete (synchronised)
serdes_ready  in  1  ADC deserialiser locked (synchronised)
axis_cmd_tdata  out  72  DataMover command
axis_cmd_tvalid  out  1  command valid
axis_cmd_tready  in  1  command accepted
s2mm_wr_xfer_cmplt  in  1  one-cycle pulse per completed command
s2mm_err  in  1  DataMover error
s2mm_halt  out  1  halt request to DataMover
s2mm_halt_cmplt  in  1  halt acknowledged
wr_ptr  out  32  completed byte offset within ring, 0..BUF_BYTES-CHUNK_BYTES
chunk_count  out  32  total completed chunks since leaving IDLE
outstanding  out  4  commands in flight
busy  out  1  state != IDLE
error  out  1  sticky DataMover error flag

Behaviour:
- Reset: state=IDLE; axis_cmd_tvalid=0; axis_cmd_tdata=0; s2mm_halt=0; wr_ptr=0; chunk_count=0; outstanding=0; busy=0; error=0. Internal issue address=BASE_ADDR; tag=0.
- Command format:
  - [22:0]=CHUNK_BYTES; [23]=1 (INCR); [29:24]=0 (DSA); [30]=1 (EOF); [31]=0 (DRR).
  - [63:32]=issue address; [67:64]=tag; [71:68]=0.
- Command handshake:
  - tdata is registered and holds stable while tvalid=1.
  - Once raised, tvalid stays high until tvalid&tready, in every state except reset.
  - On handshake: issue address += CHUNK_BYTES; if result == BASE_ADDR+BUF_BYTES it wraps to BASE_ADDR. Tag increments mod 16.
  - tvalid may re-assert the cycle after a handshake (one command per 2 cycles max).
- outstanding:
  - Increments on handshake; decrements on wr_xfer_cmplt; unchanged when both occur in the same cycle.
  - wr_xfer_cmplt with outstanding=0 and no handshake is ignored.
- Each accepted completion: wr_ptr += CHUNK_BYTES, wrapping to 0 at BUF_BYTES; chunk_count += 1, wrapping at 2^32.
- States:
  - IDLE: tvalid=0. Issue address=BASE_ADDR, tag=0, wr_ptr=0, chunk_count=0 held. enable&ddr_ready&serdes_ready -> RUN.
  - RUN: assert tvalid when outstanding+(tvalid pending) < MAX_OUTSTANDING. s2mm_err -> HALT (takes priority over enable low). !enable -> DRAIN.
  - DRAIN: no new tvalid; a pending tvalid completes its handshake. s2mm_err -> HALT. outstanding==0 and tvalid==0 -> IDLE.
  - HALT: s2mm_halt=1; error=1; pending tvalid is dropped (exception to hold rule, since the DataMover is halting). s2mm_halt_cmplt -> ERROR, s2mm_halt=0.
  - ERROR: tvalid=0; outstanding forced to 0. !enable -> IDLE and error cleared on that transition.
- ready inputs deasserting in RUN behave as !enable (-> DRAIN).
- rst mid-operation returns everything to reset values next cycle; no halt is issued.

Test Plan:
- CHUNK_BYTES=4096, BUF_BYTES=16384, MAX_OUTSTANDING=4, enable with tready=1 -> commands at SADDR 0x0,0x1000,0x2000,0x3000 with tags 0..3; tvalid low while outstanding=4; first cmplt -> next cmd SADDR 0x0, tag 4, wr_ptr=0x1000.
- tready held low 10 cycles with tvalid=1 -> tdata/tvalid stable all 10 cycles; enable dropped meanwhile -> command still accepted in DRAIN, then IDLE after 1 completion.
- Handshake and wr_xfer_cmplt in the same cycle with outstanding=2 -> outstanding stays 2, wr_ptr advances by 0x1000.
- 5 completions with BUF_BYTES=16384 -> wr_ptr sequence 0x1000,0x2000,0x3000,0x0,0x1000; chunk_count=5.
- s2mm_err pulse in RUN -> s2mm_halt=1 next cycle, error=1; halt_cmplt -> s2mm_halt=0, ERROR; enable low -> IDLE, error=0, wr_ptr=0.
- rst asserted with outstanding=3 and tvalid=1 -> next cycle all outputs at reset values; re-enable restarts at SADDR BASE_ADDR, tag 0.
